// File: rtl/tbcc_encoder_param_if.sv
// Block-level bus of the tail-biting encoder: block input stream, encoded output stream and status pulses.
// Both streams use valid/ready: a word transfers on a rising clk edge where valid and ready are both high.
// The producer holds valid and the payload steady until that edge.
interface tbcc_encoder_param_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 10
);
   logic [LEN_W-1:0]  block_len;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] d0;
   logic [DATA_W-1:0] d1;
   logic [DATA_W-1:0] d2;
   logic              computation_done;
   logic              len_err;

   modport master (
      output block_len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, d0, d1, d2, computation_done, len_err
   );

   modport slave (
      input  block_len, in_valid, in_data, out_ready,
      output in_ready, out_valid, d0, d1, d2, computation_done, len_err
   );
endinterface

// File: rtl/tbcc_encoder_param.sv
// LTE tail-biting convolutional encoder (K=7, rate 1/3, 133/171/165 octal).
// It buffers one whole block, presets the state from the block's tail and then re-reads the buffer.
module tbcc_encoder_param #(
   parameter int DATA_W    = 8,
   parameter int MAX_WORDS = 768,
   parameter int LEN_W     = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   tbcc_encoder_param_if.slave   bus,
   output logic [1:0]            dbg_state
);
   typedef enum logic [1:0] {IDLE, LOAD, ENCODE, DONE} state_t;

   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q, wr_cnt, rd_cnt, out_cnt;
   logic [DATA_W-1:0] mem [MAX_WORDS];
   logic [DATA_W-1:0] rd_data;
   logic              rd_vld;
   logic [5:0]        sreg, sreg_nxt, enc_s;
   logic [DATA_W-1:0] e0, e1, e2;
   logic              enc_c;
   logic              in_hs, out_hs, len_ok, last_in, take, rd_fire;

   assign bus.in_ready         = !reset && (state == IDLE || state == LOAD);
   assign bus.computation_done = (state == DONE);
   assign dbg_state            = state;

   assign in_hs   = bus.in_valid && bus.in_ready;
   assign out_hs  = bus.out_valid && bus.out_ready;
   assign len_ok  = (bus.block_len != '0) && (bus.block_len <= MAX_LEN);
   assign last_in = in_hs && (((state == IDLE) && len_ok && (bus.block_len == ONE)) ||
                              ((state == LOAD) && (wr_cnt == len_q - ONE)));
   // Read stage refills whenever its word is consumed, so a steady out_ready gives one word per cycle.
   assign take    = (state == ENCODE) && rd_vld && (!bus.out_valid || bus.out_ready);
   assign rd_fire = (state == ENCODE) && (rd_cnt != len_q) && (!rd_vld || take);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_hs && len_ok) state_nxt = (bus.block_len == ONE) ? ENCODE : LOAD;
         LOAD:    if (last_in) state_nxt = ENCODE;
         ENCODE:  if (out_hs && (out_cnt == len_q - ONE)) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bit-serial recurrence unrolled across one word; sreg[j-1] holds c(k-j).
   always_comb begin
      enc_s = sreg;
      enc_c = 1'b0;
      e0    = '0;
      e1    = '0;
      e2    = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         enc_c = rd_data[i];
         e0[i] = enc_c ^ enc_s[1] ^ enc_s[2] ^ enc_s[4] ^ enc_s[5];
         e1[i] = enc_c ^ enc_s[0] ^ enc_s[1] ^ enc_s[2] ^ enc_s[5];
         e2[i] = enc_c ^ enc_s[0] ^ enc_s[1] ^ enc_s[3] ^ enc_s[5];
         enc_s = {enc_s[4:0], enc_c};
      end
      sreg_nxt = enc_s;
   end

   always_ff @(posedge clk) begin
      if (in_hs && ((state == LOAD) || ((state == IDLE) && len_ok)))
         mem[(state == IDLE) ? '0 : wr_cnt] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rd_fire) rd_data <= mem[rd_cnt];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q         <= '0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         out_cnt       <= '0;
         rd_vld        <= 1'b0;
         sreg          <= '0;
         bus.out_valid <= 1'b0;
         bus.d0        <= '0;
         bus.d1        <= '0;
         bus.d2        <= '0;
         bus.len_err   <= 1'b0;
      end else begin
         bus.len_err <= (state == IDLE) && in_hs && !len_ok;
         if ((state == IDLE) && in_hs) len_q <= bus.block_len;
         if (in_hs) wr_cnt <= (state == IDLE) ? ONE : wr_cnt + ONE;
         // The last word's low bits are the final six input bits: the tail-biting start state.
         if (last_in)   sreg <= bus.in_data[5:0];
         else if (take) sreg <= sreg_nxt;
         if (state != ENCODE) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            rd_vld  <= 1'b0;
         end else begin
            if (rd_fire) begin
               rd_cnt <= rd_cnt + ONE;
               rd_vld <= 1'b1;
            end else if (take) begin
               rd_vld <= 1'b0;
            end
            if (out_hs) out_cnt <= out_cnt + ONE;
         end
         if (take) begin
            bus.out_valid <= 1'b1;
            bus.d0        <= e0;
            bus.d1        <= e1;
            bus.d2        <= e2;
         end else if (out_hs) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tbcc_encoder_param.sv
// Self-checking bench for tbcc_encoder_param: directed vectors, full-length blocks, random blocks against a
// circular-convolution reference model, length errors and mid-block resets.
module tb_tbcc_encoder_param;
   localparam int DW = 8;
   localparam int MW = 768;
   localparam int LW = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;

   tbcc_encoder_param_if #(.DATA_W(DW), .LEN_W(LW)) bif ();

   tbcc_encoder_param #(.DATA_W(DW), .MAX_WORDS(MW), .LEN_W(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bif.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int              n_checks = 0;
   int              n_fail   = 0;
   logic [3*DW-1:0] exp_q[$];
   logic [DW-1:0]   blk[MW];

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each output bit is a circular XOR over the whole block's bit sequence.
   task automatic build_exp(input int len);
      bit            cb[DW*MW];
      int            t0[5] = '{0, 2, 3, 5, 6};
      int            t1[5] = '{0, 1, 2, 3, 6};
      int            t2[5] = '{0, 1, 2, 4, 6};
      int            n;
      int            k;
      bit            x0, x1, x2;
      logic [DW-1:0] w0, w1, w2;
      n = len * DW;
      for (int i = 0; i < n; i++) cb[i] = blk[i / DW][DW - 1 - (i % DW)];
      for (int w = 0; w < len; w++) begin
         for (int b = 0; b < DW; b++) begin
            k  = w * DW + b;
            x0 = 0; x1 = 0; x2 = 0;
            for (int j = 0; j < 5; j++) begin
               x0 ^= cb[(k - t0[j] + n) % n];
               x1 ^= cb[(k - t1[j] + n) % n];
               x2 ^= cb[(k - t2[j] + n) % n];
            end
            w0[DW-1-b] = x0; w1[DW-1-b] = x1; w2[DW-1-b] = x2;
         end
         exp_q.push_back({w0, w1, w2});
      end
   endtask

   task automatic wait_hs(input string tag);
      logic hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
         @(negedge clk);
         hs = bif.in_ready;
         @(posedge clk); #1;
      end
      chk({tag, "_in_hs"}, 32'(hs), 1);
   endtask

   task automatic send_words(input int len, input int count);
      for (int i = 0; i < count; i++) begin
         bif.in_valid  = 1'b1;
         bif.in_data   = blk[i];
         bif.block_len = (i == 0) ? LW'(len) : LW'($urandom);
         wait_hs("send");
      end
   endtask

   task automatic recv(input int take, input bit rand_rdy, input bit expect_done, input string tag);
      int              got = 0;
      int              cyc = 0;
      int              first = -1;
      logic            pv = 1'b0;
      logic            pr = 1'b0;
      logic [3*DW-1:0] pd = '0;
      while (got < take && cyc < 5000) begin
         bif.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         chk({tag, "_in_ready_low"}, 32'(bif.in_ready), 0);
         chk({tag, "_no_early_done"}, 32'(bif.computation_done), 0);
         if (bif.out_valid && first < 0) begin
            first = cyc;
            chk({tag, "_latency"}, 32'(first), 2);
         end
         if (pv && !pr) begin
            chk({tag, "_stall_valid"}, 32'(bif.out_valid), 1);
            chk({tag, "_stall_data"}, 32'({bif.d0, bif.d1, bif.d2}), 32'(pd));
         end
         if (bif.out_valid && bif.out_ready) begin
            got++;
            if (exp_q.size() == 0) chk({tag, "_extra_word"}, 32'(got), 0);
            else chk({tag, "_data"}, 32'({bif.d0, bif.d1, bif.d2}), 32'(exp_q.pop_front()));
         end
         pv = bif.out_valid;
         pr = bif.out_ready;
         pd = {bif.d0, bif.d1, bif.d2};
         cyc++;
         @(posedge clk); #1;
      end
      chk({tag, "_word_count"}, 32'(got), 32'(take));
      bif.out_ready = 1'b0;
      if (expect_done) begin
         @(negedge clk);
         chk({tag, "_done_pulse"}, 32'(bif.computation_done), 1);
         chk({tag, "_done_valid_low"}, 32'(bif.out_valid), 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk({tag, "_done_single"}, 32'(bif.computation_done), 0);
         chk({tag, "_ready_back"}, 32'(bif.in_ready), 1);
         @(posedge clk); #1;
      end
   endtask

   task automatic directed(input logic [DW-1:0] data, input logic [3*DW-1:0] exp, input string tag);
      blk[0] = data;
      send_words(1, 1);
      bif.in_valid = 1'b0;
      exp_q.push_back(exp);
      recv(1, 1'b0, 1'b1, tag);
   endtask

   task automatic bad_len(input logic [LW-1:0] len, input string tag);
      bif.block_len = len;
      bif.in_data   = DW'($urandom);
      bif.in_valid  = 1'b1;
      @(negedge clk);
      chk({tag, "_accepted"}, 32'(bif.in_ready), 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_len_err"}, 32'(bif.len_err), 1);
      chk({tag, "_in_ready"}, 32'(bif.in_ready), 1);
      chk({tag, "_no_output"}, 32'(bif.out_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_len_err_pulse"}, 32'(bif.len_err), 0);
      chk({tag, "_still_idle"}, 32'(bif.out_valid), 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready_in_reset"}, 32'(bif.in_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      bif.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk({tag, "_valid_cleared"}, 32'(bif.out_valid), 0);
         chk({tag, "_d_cleared"}, 32'({bif.d0, bif.d1, bif.d2}), 0);
         chk({tag, "_no_done"}, 32'(bif.computation_done), 0);
         chk({tag, "_in_ready"}, 32'(bif.in_ready), 1);
         @(posedge clk); #1;
      end
      exp_q.delete();
   endtask

   initial begin
      int len;
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.block_len = '0;
      bif.out_ready = 1'b0;
      reset         = 1'b1;

      // Clock/reset phase
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", 32'(bif.in_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_after", 32'(bif.in_ready), 1);
      chk("rst_out_valid", 32'(bif.out_valid), 0);
      chk("rst_d", 32'({bif.d0, bif.d1, bif.d2}), 0);
      chk("rst_done", 32'(bif.computation_done), 0);
      chk("rst_len_err", 32'(bif.len_err), 0);
      chk("rst_state", 32'(dbg_state), 0);
      @(posedge clk); #1;

      directed(8'h80, 24'hB6F2EA, "vec80");
      directed(8'h01, 24'h6DE5D5, "vec01");

      for (int i = 0; i < MW; i++) blk[i] = 8'hFF;
      send_words(MW, MW);
      bif.in_valid = 1'b0;
      for (int i = 0; i < MW; i++) exp_q.push_back(24'hFFFFFF);
      recv(MW, 1'b0, 1'b1, "ones");

      for (int i = 0; i < MW; i++) blk[i] = 8'h00;
      send_words(MW, MW);
      bif.in_valid = 1'b0;
      for (int i = 0; i < MW; i++) exp_q.push_back(24'h000000);
      recv(MW, 1'b0, 1'b1, "zeros");

      for (int i = 0; i < 12; i++) blk[i] = DW'($urandom);
      send_words(12, 12);
      bif.in_valid = 1'b0;
      build_exp(12);
      recv(12, 1'b1, 1'b1, "rand12");

      for (int b = 0; b < 6; b++) begin
         len = (b == 0) ? 2 : int'($urandom_range(1, 40));
         for (int i = 0; i < len; i++) blk[i] = DW'($urandom);
         send_words(len, len);
         bif.in_valid = 1'b0;
         build_exp(len);
         recv(len, 1'b1, 1'b1, "randlen");
      end

      bad_len(LW'(0), "len0");
      bad_len(LW'(769), "len769");
      directed(8'h80, 24'hB6F2EA, "after_err");

      for (int i = 0; i < 12; i++) blk[i] = DW'($urandom);
      send_words(12, 5);
      bif.in_valid = 1'b1;
      bif.in_data  = blk[5];
      pulse_reset("rst_load");
      directed(8'h01, 24'h6DE5D5, "after_rst_load");

      for (int i = 0; i < 12; i++) blk[i] = DW'($urandom);
      send_words(12, 12);
      bif.in_valid = 1'b0;
      build_exp(12);
      recv(4, 1'b0, 1'b0, "pre_rst_enc");
      pulse_reset("rst_enc");
      directed(8'h01, 24'h6DE5D5, "after_rst_enc");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
